multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory handshakes, a sticky illegal-opcode halt and a retire counter.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_rd_req,
  output logic        dmem_wr_req,
  output logic [3:0]  alu_control_signal,
  output logic        alu_src_imm,
  output logic        Branch,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] retire_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [2:0]  state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        funct7b5_q, funct7b5_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic is_r, is_i, is_ld, is_sd, is_beq, opcode_legal;
  logic [3:0] alu_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_FETCH;
      opcode_q       <= '0;
      funct3_q       <= '0;
      funct7b5_q     <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      funct3_q       <= funct3_d;
      funct7b5_q     <= funct7b5_d;
      retire_count_q <= retire_count_d;
    end
  end

  always_comb begin
    is_r   = (opcode_q == OP_R);
    is_i   = (opcode_q == OP_I);
    is_ld  = (opcode_q == OP_LD);
    is_sd  = (opcode_q == OP_SD);
    is_beq = (opcode_q == OP_BEQ);
    opcode_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                   (opcode == OP_SD) || (opcode == OP_BEQ);
    alu_sel = 4'b0010;
    if (is_beq) begin
      alu_sel = 4'b0110;
    end else if (is_r) begin
      case (funct3_q)
        3'b000:  alu_sel = funct7b5_q ? 4'b0110 : 4'b0010;
        3'b111:  alu_sel = 4'b0000;
        3'b110:  alu_sel = 4'b0001;
        default: alu_sel = 4'b0010;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    funct3_d       = funct3_q;
    funct7b5_d     = funct7b5_q;
    retire_count_d = retire_count_q + {31'd0, pc_we};
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d   = opcode;
        funct3_d   = funct3;
        funct7b5_d = funct7b5;
        state_d    = opcode_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (is_beq)              state_d = S_FETCH;
        else if (is_ld || is_sd) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM:    if (dmem_ready) state_d = is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset_n is asserted, even though state already reads FETCH.
  always_comb begin
    imem_req           = 1'b0;
    ir_we              = 1'b0;
    dmem_rd_req        = 1'b0;
    dmem_wr_req        = 1'b0;
    alu_control_signal = 4'b0000;
    alu_src_imm        = 1'b0;
    Branch             = 1'b0;
    pc_we              = 1'b0;
    reg_we             = 1'b0;
    mem_to_reg         = 1'b0;
    halted             = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          alu_control_signal = alu_sel;
          alu_src_imm        = is_i || is_ld || is_sd;
          Branch             = is_beq;
          pc_we              = is_beq;
        end
        S_MEM: begin
          dmem_rd_req = is_ld;
          dmem_wr_req = is_sd;
          // Store retires in the completing cycle only, so pc_we pulses once however long the wait.
          pc_we       = is_sd && dmem_ready;
        end
        S_WB: begin
          reg_we     = 1'b1;
          pc_we      = 1'b1;
          mem_to_reg = is_ld;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state        = state_q;
  assign retire_count = retire_count_q;

endmodule
